// File: rtl/marquee_pkg.sv
// marquee_pkg: shared definitions for the ASCII marquee.
//   state_t    : controller states (LOAD = accepting message bytes, SCROLL = stepping text)
//   SPACE_CHAR : blank glyph; decodes to all segments off
package marquee_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    SCROLL = 1'b1
  } state_t;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider producing the scroll step strobe.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, counter -> 0
//   clr   : synchronous counter clear (restart of the step period)
//   hold  : freeze the counter; also masks step
//   step  : one-cycle pulse on the terminal count (TICK_DIV-1)
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic step
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign step = !hold && (32'(cnt_q) == 32'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= step ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ascii_marquee.sv
// ascii_marquee: buffers an ASCII message and scrolls it right-to-left
// across NUM_DIGITS seven-segment character slots.
//   clk, reset : clock and synchronous active-high reset
//   wr_en/wr_char/wr_ready : byte append interface (accepted when wr_en && wr_ready)
//   start      : begin scrolling (needs a non-empty message)
//   pause      : freeze scroll timing while high
//   clear      : empty the message and return to LOAD
//   char_out   : slot i at [8*(NUM_DIGITS-i)-1 -: 8], slot 0 leftmost
//   busy       : high while scrolling
//   wrap_pulse : one-cycle pulse after the read pointer wraps to 0
// Build option: MARQUEE_BLANK_PAD_EN appends NUM_DIGITS blanks to the
// scroll period so the text leaves the display before repeating.
module ascii_marquee
  import marquee_pkg::*;
#(
  parameter int MSG_DEPTH  = 32,
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [7:0]              wr_char,
  output logic                    wr_ready,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    clear,
  output logic [8*NUM_DIGITS-1:0] char_out,
  output logic                    busy,
  output logic                    wrap_pulse
);

  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
`ifdef MARQUEE_BLANK_PAD_EN
  localparam int PMAX = MSG_DEPTH + NUM_DIGITS;
`else
  localparam int PMAX = MSG_DEPTH;
`endif
  localparam int PW = (PMAX > 1) ? $clog2(PMAX) : 1;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q;
  logic [PW-1:0] rd_ptr_q;
  logic [7:0]    mem [MSG_DEPTH];
  logic [7:0]    slot_q [NUM_DIGITS];

  logic          do_start, do_write, do_step, do_shift;
  logic [7:0]    shift_char, next_char;
  logic [31:0]   last_idx;
  logic          at_last, step;

  assign wr_ready = (state_q == LOAD) && (32'(len_q) < 32'(MSG_DEPTH));
  assign busy     = (state_q == SCROLL);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clear || do_start),
    .hold  (pause || (state_q != SCROLL)),
    .step  (step)
  );

  always_comb begin
    state_d    = state_q;
    do_start   = 1'b0;
    do_write   = 1'b0;
    do_step    = 1'b0;
    do_shift   = 1'b0;
    shift_char = SPACE_CHAR;
`ifdef MARQUEE_BLANK_PAD_EN
    last_idx   = 32'(len_q) + 32'(NUM_DIGITS) - 32'd1;
`else
    last_idx   = 32'(len_q) - 32'd1;
`endif
    at_last    = (32'(rd_ptr_q) == last_idx);
    // Positions past the stored message read as blanks (padding region).
    next_char  = (32'(rd_ptr_q) < 32'(len_q)) ? mem[rd_ptr_q[AW-1:0]] : SPACE_CHAR;

    if (clear) begin
      state_d = LOAD;
    end else if (start && (state_q == LOAD) && (len_q != '0)) begin
      state_d  = SCROLL;
      do_start = 1'b1;
    end else if (wr_en && wr_ready) begin
      do_write   = 1'b1;
      do_shift   = 1'b1;
      shift_char = wr_char;
    end else if (step && (state_q == SCROLL)) begin
      do_step    = 1'b1;
      do_shift   = 1'b1;
      shift_char = next_char;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      wrap_pulse <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) slot_q[i] <= SPACE_CHAR;
    end else begin
      state_q    <= state_d;
      wrap_pulse <= do_step && at_last;
      if (clear || do_start) begin
        rd_ptr_q <= '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) slot_q[i] <= SPACE_CHAR;
      end else if (do_shift) begin
        for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) slot_q[i] <= slot_q[i+1];
        slot_q[NUM_DIGITS-1] <= shift_char;
      end
      if (clear) begin
        len_q <= '0;
      end else if (do_write) begin
        len_q <= len_q + LW'(1);
      end
      if (do_step) begin
        rd_ptr_q <= at_last ? '0 : rd_ptr_q + PW'(1);
      end
    end
  end

  // Message storage carries no reset; len_q alone defines valid content.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[len_q[AW-1:0]] <= wr_char;
    end
  end

  always_comb begin
    char_out = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      char_out[8*(NUM_DIGITS-i)-1 -: 8] = slot_q[i];
    end
  end

endmodule

// File: doc/ascii_marquee.md
# ascii_marquee

Scrolling-text source for the seven-segment display bank. Buffers an ASCII message written one byte at a time, then shifts it right-to-left across NUM_DIGITS character slots at a fixed tick rate. Each 8-bit slot of `char_out` drives one ASCII-to-seven-segment decoder instance directly. Space (8'h20) is the blank character; it decodes to all segments off.

## Interface
- `MSG_DEPTH`, 32: message buffer capacity in characters (≥1).
- `NUM_DIGITS`, 6: number of display slots (≥1).
- `TICK_DIV`, 25_000_000: clock cycles per scroll step (≥2).

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  write request; byte accepted when `wr_en && wr_ready`.
- `wr_char`  in  8  ASCII byte to append.
- `wr_ready`  out  1  buffer accepts a write this cycle.
- `start`  in  1  begin scrolling (level or pulse; sampled each cycle).
- `pause`  in  1  freeze scroll timing while high.
- `clear`  in  1  empty buffer, return to LOAD.
- `char_out`  out  8*NUM_DIGITS  slot i at `[8*(NUM_DIGITS-i)-1 -: 8]`, i=0 leftmost.
- `busy`  out  1  high in SCROLL.
- `wrap_pulse`  out  1  one-cycle pulse when the read pointer wraps.

## Operation
- States: LOAD, SCROLL. Reset → LOAD; `len`=0, `rd_ptr`=0, tick counter=0, every slot of `char_out`=8'h20, `busy`=0, `wrap_pulse`=0.
- Priority each cycle: `reset` > `clear` > `start` > `wr_en`.
- `wr_ready` = (state==LOAD) && (`len` < MSG_DEPTH); purely combinational.
- LOAD, accepted write: `buf[len]`←`wr_char`, `len`++. `char_out` shifts left one slot, `wr_char` enters slot NUM_DIGITS-1 (typewriter preview).
- Write while full or while in SCROLL: ignored; no state change.
- `clear` in either state: `len`←0, `rd_ptr`←0, tick←0, all slots←8'h20, state→LOAD. A same-cycle write is dropped.
- `start` in LOAD with `len`≥1: state→SCROLL, all slots←8'h20, `rd_ptr`←0, tick←0. `start` with `len`=0: ignored. `start` in SCROLL: no effect.
- SCROLL: tick counts 0..TICK_DIV-1 while `pause`=0 and holds while `pause`=1. On a terminal count (step): `char_out` shifts left one slot, `vchar(rd_ptr)` enters the rightmost slot, and `rd_ptr` advances modulo P.
- `vchar(k)` = `buf[k]` if k < `len`, else 8'h20. Scroll period P defined under Configuration.
- `wrap_pulse`=1 in the cycle after a step that moves `rd_ptr` from P-1 to 0; otherwise 0.
- Widths: `len` holds 0..MSG_DEPTH (clog2(MSG_DEPTH+1) bits). `rd_ptr` and tick use clog2 widths. Comparisons are unsigned; no modulo hardware, wrap is compare-and-reset.

## Timing
- All outputs registered except `wr_ready`.
- Write accepted at edge t → `char_out` updated at t+1.
- `start` at edge t → `busy`=1 and blank slots at t+1. First step at edge t+TICK_DIV, with no pause.
- Steady state: one step per TICK_DIV unpaused cycles. `pause` asserted on the terminal-count cycle suppresses that step.
- `reset` or `clear` mid-scroll takes effect at the next edge. There is no partial step.

## Configuration
- `MARQUEE_BLANK_PAD_EN` defined: P = `len` + NUM_DIGITS. NUM_DIGITS trailing spaces let the message scroll fully off before repeating.
- Not defined: P = `len`. The message repeats back-to-back with no gap. A message shorter than NUM_DIGITS tiles across the display.

## Structure
- `marquee_pkg`: state enum (LOAD, SCROLL), `SPACE_CHAR` = 8'h20.
- Sub-module `tick_prescaler`: parameter TICK_DIV; inputs `clk`, `reset`, `clr`, `hold`; output `step` is a one-cycle pulse at terminal count. Prescaler reset value is 0.

## Test plan
- TICK_DIV=4, NUM_DIGITS=6, pad on. Write "HI" (48,49), then start. Each step: rightmost slot shows 48, then 49, then 20×6. `wrap_pulse` fires after the 8th step; slot 0 shows 48 after the 6th step.
- Pad off, same stimulus. Rightmost sequence is 48,49,48,49…, `wrap_pulse` every 2 steps. After 6 steps `char_out` = 48 49 48 49 48 49.
- Write 33 bytes with MSG_DEPTH=32. `wr_ready` drops after the 32nd write. The 33rd byte is ignored and `len`=32.
- During SCROLL, assert `clear` and `start` together. Next cycle: state LOAD, all slots 20, `busy`=0, `wr_ready`=1.
- Hold `pause` for 10 cycles mid-scroll. No step occurs, the tick count is frozen, and the step resumes exactly TICK_DIV-remaining cycles after release.
- Assert `reset` mid-scroll and during a write. All outputs return to reset values next cycle, and a subsequent `start` is ignored because `len`=0.
